instr_fetch: RTL and testbench

Instruction-fetch stage of the i281 datapath: owns the program counter register and the 64-word instruction memory, presents the fetched instruction to the opcode decoder, and latches the next PC computed downstream by the PC-update logic. It sits directly upstream of PC update: its `pc` output feeds PC update's current PC, its `instr[5:0]` supplies the branch offset, and PC update's `next_pc` returns here. It also provides a program-load port, run/single-step control and jump-to-self halt detection.

---
 rtl/instr_fetch.sv | 127 ++++++++++++
 tb/tb_instr_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//   Instruction-fetch stage of the i281 datapath. Owns the program counter and
//   the 64-word instruction memory, presents the fetched instruction to the
//   decoder, and latches the next PC computed downstream by PC update.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   prog_we      : memory write strobe (IDLE only)
//   prog_addr    : memory write address
//   prog_data    : memory write data
//   start        : pulse, begin execution at PC 0 (IDLE only)
//   step_mode    : 1 = pause after each issued instruction
//   step         : pulse, releases PAUSE
//   abort        : pulse, return to IDLE from any state
//   next_pc      : next PC from PC update, sampled on the issue handshake
//   instr_ready  : decoder accepts the current instruction
//   pc           : current PC (address of instr while instr_valid)
//   instr        : fetched instruction register
//   instr_valid  : instr is valid for pc (high exactly in ISSUE)
//   busy         : state is neither IDLE nor HALT
//   halted       : state is HALT
//   state_dbg    : current FSM state encoding, for checkers
//
// Handshake: instr_valid/instr_ready. While instr_valid is high, pc and instr
// are held stable; an instruction is issued on every rising edge where both
// instr_valid and instr_ready are high, and next_pc is sampled on that edge
// only. instr_valid never depends combinationally on instr_ready.
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter int PC_W    = 6,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 64   // must equal 2**PC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               step_mode,
  input  logic               step,
  input  logic               abort,
  input  logic [PC_W-1:0]    next_pc,
  input  logic               instr_ready,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               halted,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_PAUSE = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state, state_next;

  logic [INSTR_W-1:0] mem [DEPTH];

  logic handshake;
  assign handshake = (state == S_ISSUE) && instr_ready;

  // Next-state logic. abort overrides every other transition.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_FETCH;
      S_FETCH: state_next = S_ISSUE;
      S_ISSUE: begin
        if (instr_ready) begin
          if (next_pc == pc)  state_next = S_HALT;  // jump to self
          else if (step_mode) state_next = S_PAUSE;
          else                state_next = S_FETCH;
        end
      end
      S_PAUSE: if (step) state_next = S_FETCH;
      S_HALT:  state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_next;
      // Registered so instr_valid is glitch-free and high exactly in ISSUE.
      instr_valid <= (state_next == S_ISSUE);

      if (abort) begin
        pc <= '0;
      end else if (state == S_IDLE && start) begin
        pc <= '0;
      end else if (handshake) begin
        // On a jump to self next_pc equals pc, so HALT keeps the halting address.
        pc <= next_pc;
      end

      // instr is kept across abort; only a FETCH replaces it.
      if (state == S_FETCH && !abort) begin
        instr <= mem[pc];
      end
    end
  end

  // Memory is not reset; writes are accepted only while idle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_HALT);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//   Self-checking bench for instr_fetch: directed vector table, hand-written
//   multi-cycle sequences, and a randomized run against a transaction-level
//   model (model memory plus an expected-issue queue).
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  localparam int PC_W    = 6;
  localparam int INSTR_W = 16;
  localparam int DEPTH   = 64;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               prog_we     = 1'b0;
  logic [PC_W-1:0]    prog_addr   = '0;
  logic [INSTR_W-1:0] prog_data   = '0;
  logic               start       = 1'b0;
  logic               step_mode   = 1'b0;
  logic               step        = 1'b0;
  logic               abort       = 1'b0;
  logic [PC_W-1:0]    next_pc     = '0;
  logic               instr_ready = 1'b0;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               busy;
  logic               halted;
  logic [2:0]         state_dbg;

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .step_mode(step_mode), .step(step), .abort(abort),
    .next_pc(next_pc), .instr_ready(instr_ready),
    .pc(pc), .instr(instr), .instr_valid(instr_valid),
    .busy(busy), .halted(halted), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [INSTR_W-1:0] model_mem [DEPTH];
  logic [PC_W+INSTR_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d);
    prog_addr = a;
    prog_data = d;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic start_pulse;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_pulse;
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic wait_valid;
    int n;
    n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    if (!instr_valid) check("wait_valid_timeout", 32'(instr_valid), 32'd1);
  endtask

  // Hold instr_ready low for 'hold' cycles (with a decoy next_pc), then issue.
  task automatic handshake(input logic [PC_W-1:0] np, input int hold);
    logic [PC_W-1:0]    h_pc;
    logic [INSTR_W-1:0] h_instr;
    h_pc    = pc;
    h_instr = instr;
    for (int i = 0; i < hold; i++) begin
      next_pc     = 6'd50;
      instr_ready = 1'b0;
      tick();
      check("bp_pc",    32'(pc),          32'(h_pc));
      check("bp_instr", 32'(instr),       32'(h_instr));
      check("bp_valid", 32'(instr_valid), 32'd1);
    end
    next_pc     = np;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  function automatic logic [INSTR_W-1:0] prog_word(input int i);
    if (i < 4) return INSTR_W'(i);
    return 16'hC000 + INSTR_W'(i * 16'h0101);
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [PC_W-1:0]    np;
    int                 hold;
    logic [PC_W-1:0]    exp_pc;
    logic [INSTR_W-1:0] exp_instr;
  } vec_t;

  vec_t vecs[6];

  // Global time bound so the run always terminates.
  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PC_W+INSTR_W-1:0] exp_e;
    logic [PC_W-1:0]    model_pc;
    logic [PC_W-1:0]    hold_pc;
    logic [INSTR_W-1:0] hold_instr;
    logic hold_v, halt_pend;
    int since_hs, idle_cnt, issued, r;

    // ---- reset values ----
    #3;
    check("rst_pc",     32'(pc),          32'd0);
    check("rst_instr",  32'(instr),       32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_busy",   32'(busy),        32'd0);
    check("rst_halted", 32'(halted),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ---- program load ----
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = prog_word(i);
      load(PC_W'(i), prog_word(i));
    end

    // ---- start latency ----
    start_pulse();
    check("start_fetch_busy",  32'(busy),        32'd1);
    check("start_fetch_valid", 32'(instr_valid), 32'd0);
    check("start_fetch_pc",    32'(pc),          32'd0);
    tick();
    check("start_issue_valid", 32'(instr_valid), 32'd1);

    // ---- straight line, back-pressure, branch, halt ----
    vecs[0] = '{np: 6'd1, hold: 0, exp_pc: 6'd0, exp_instr: model_mem[0]};
    vecs[1] = '{np: 6'd2, hold: 0, exp_pc: 6'd1, exp_instr: model_mem[1]};
    vecs[2] = '{np: 6'd3, hold: 5, exp_pc: 6'd2, exp_instr: model_mem[2]};
    vecs[3] = '{np: 6'd4, hold: 0, exp_pc: 6'd3, exp_instr: model_mem[3]};
    vecs[4] = '{np: 6'd9, hold: 0, exp_pc: 6'd4, exp_instr: model_mem[4]};
    vecs[5] = '{np: 6'd9, hold: 0, exp_pc: 6'd9, exp_instr: model_mem[9]};

    for (int v = 0; v < 6; v++) begin
      wait_valid();
      check("vec_pc",    32'(pc),    32'(vecs[v].exp_pc));
      check("vec_instr", 32'(instr), 32'(vecs[v].exp_instr));
      handshake(vecs[v].np, vecs[v].hold);
      if (vecs[v].np == vecs[v].exp_pc) begin
        check("halt_halted", 32'(halted),      32'd1);
        check("halt_busy",   32'(busy),        32'd0);
        check("halt_pc",     32'(pc),          32'(vecs[v].np));
        check("halt_valid",  32'(instr_valid), 32'd0);
      end else begin
        check("hs_fetch_valid", 32'(instr_valid), 32'd0);
        check("hs_fetch_pc",    32'(pc),          32'(vecs[v].np));
        tick();
        check("hs_issue_valid", 32'(instr_valid), 32'd1);
      end
    end

    // HALT holds through start; only abort leaves it.
    start_pulse();
    repeat (2) tick();
    check("halt_hold", 32'(halted), 32'd1);
    check("halt_hold_pc", 32'(pc), 32'd9);
    abort_pulse();
    check("abort_halted", 32'(halted),      32'd0);
    check("abort_busy",   32'(busy),        32'd0);
    check("abort_pc",     32'(pc),          32'd0);
    check("abort_valid",  32'(instr_valid), 32'd0);
    check("abort_instr",  32'(instr),       32'(model_mem[9]));

    // ---- single step ----
    step_mode = 1'b1;
    start_pulse();
    for (int s = 0; s < 2; s++) begin
      wait_valid();
      check("ss_pc", 32'(pc), s);
      handshake(PC_W'(s + 1), 0);
      check("ss_pause_valid", 32'(instr_valid), 32'd0);
      check("ss_pause_busy",  32'(busy),        32'd1);
      check("ss_pause_pc",    32'(pc),          32'(s + 1));
      repeat (3) tick();
      check("ss_pause_hold", 32'(instr_valid), 32'd0);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("ss_fetch_valid", 32'(instr_valid), 32'd0);
      tick();
      check("ss_issue_valid", 32'(instr_valid), 32'd1);
      check("ss_issue_instr", 32'(instr),       32'(model_mem[s + 1]));
    end
    // abort coincident with a handshake wins
    abort       = 1'b1;
    instr_ready = 1'b1;
    next_pc     = 6'd5;
    tick();
    abort       = 1'b0;
    instr_ready = 1'b0;
    check("abort_hs_pc",    32'(pc),          32'd0);
    check("abort_hs_busy",  32'(busy),        32'd0);
    check("abort_hs_valid", 32'(instr_valid), 32'd0);
    step_mode = 1'b0;

    // ---- prog_we outside IDLE is ignored; inside IDLE it takes effect ----
    start_pulse();
    prog_addr = 6'd7;
    prog_data = 16'hDEAD;
    prog_we   = 1'b1;
    tick();
    prog_we   = 1'b0;
    abort_pulse();
    start_pulse();
    wait_valid();
    handshake(6'd7, 0);
    wait_valid();
    check("we_fetch_ignored", 32'(instr), 32'(model_mem[7]));
    abort_pulse();
    load(6'd7, 16'hDEAD);
    model_mem[7] = 16'hDEAD;
    start_pulse();
    wait_valid();
    handshake(6'd7, 0);
    wait_valid();
    check("we_idle_taken", 32'(instr), 32'h0000DEAD);

    // ---- async reset mid-ISSUE ----
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc",     32'(pc),          32'd0);
    check("arst_instr",  32'(instr),       32'd0);
    check("arst_valid",  32'(instr_valid), 32'd0);
    check("arst_busy",   32'(busy),        32'd0);
    check("arst_halted", 32'(halted),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_idle_busy",  32'(busy),        32'd0);
    check("arst_idle_valid", 32'(instr_valid), 32'd0);

    // ---- randomized run against the transaction model ----
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = INSTR_W'($urandom_range(0, 65535));
      load(PC_W'(i), model_mem[i]);
    end
    start_pulse();
    model_pc = '0;
    exp_q.push_back({6'd0, model_mem[0]});
    hold_v    = 1'b0;
    halt_pend = 1'b0;
    since_hs  = -1;
    idle_cnt  = 0;
    issued    = 0;
    for (int cyc = 0; cyc < 4000 && issued < 300; cyc++) begin
      @(posedge clk);
      #1;
      instr_ready = ($urandom_range(0, 1) == 1);
      r = int'($urandom_range(0, 15));
      if (r == 0)      next_pc = model_pc;
      else if (r < 10) next_pc = model_pc + 6'd1;
      else             next_pc = PC_W'($urandom_range(0, 63));
      @(negedge clk);

      if (hold_v) begin
        check("rnd_hold_pc",    32'(pc),          32'(hold_pc));
        check("rnd_hold_instr", 32'(instr),       32'(hold_instr));
        check("rnd_hold_valid", 32'(instr_valid), 32'd1);
      end
      hold_v = 1'b0;

      if (since_hs >= 0) begin
        since_hs++;
        if (since_hs == 1) check("rnd_gap_fetch", 32'(instr_valid), 32'd0);
        if (since_hs == 2) begin
          check("rnd_gap_issue", 32'(instr_valid), 32'd1);
          since_hs = -1;
        end
      end

      if (instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_unexpected_issue", 32'd1, 32'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("rnd_pc",    32'(pc),    32'(exp_e[PC_W+INSTR_W-1:INSTR_W]));
          check("rnd_instr", 32'(instr), 32'(exp_e[INSTR_W-1:0]));
        end
        issued++;
        idle_cnt = 0;
        if (next_pc == model_pc) begin
          halt_pend = 1'b1;
        end else begin
          exp_q.push_back({next_pc, model_mem[next_pc]});
          since_hs = 0;
        end
        model_pc = next_pc;
      end else if (instr_valid) begin
        hold_v     = 1'b1;
        hold_pc    = pc;
        hold_instr = instr;
      end

      if (halt_pend) begin
        @(posedge clk);
        #1;
        instr_ready = 1'b0;
        check("rnd_halted",  32'(halted), 32'd1);
        check("rnd_halt_pc", 32'(pc),     32'(model_pc));
        abort_pulse();
        start_pulse();
        model_pc = '0;
        exp_q.push_back({6'd0, model_mem[0]});
        halt_pend = 1'b0;
      end

      idle_cnt++;
      if (idle_cnt > 40) begin
        check("rnd_watchdog", 32'd0, 32'd1);
        break;
      end
    end
    instr_ready = 1'b0;
    check("rnd_issued_enough", 32'(issued >= 300), 32'd1);
    check("rnd_queue_depth",   32'(exp_q.size()),  32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
